motor_mode_sequencer: RTL and testbench

Sequences the motor-setting path between the assistance/throttle sources and current control. Selects assist or twist-throttle source, enforces an arming interlock, kills output immediately on excessive roll/pitch, rate-limits the setting and (optionally) coasts to zero when pedalling stops. Its output drives the AssistanceRequirement input of current control.

---
 rtl/motor_seq_pkg.sv | 26 ++
 rtl/motor_mode_sequencer_if.sv | 28 ++
 rtl/ramp_limiter.sv | 31 +++
 rtl/motor_mode_sequencer.sv | 138 +++++++++++++
 tb/tb_motor_mode_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_seq_pkg.sv
// Shared types, default tuning constants and helpers for the motor mode sequencer.
package motor_seq_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_RUN   = 2'd1,
      SEQ_COAST = 2'd2,
      SEQ_FAULT = 2'd3
   } seq_state_t;

   typedef logic [11:0] setting_t;

   // 12-bit angles: 2048 = 180 deg, so 512 = 45 deg; ticks are 20 kHz
   localparam int unsigned DEF_TILT_LIMIT             = 512;
   localparam int unsigned DEF_RAMP_STEP              = 16;
   localparam int unsigned DEF_ZERO_THRESH            = 32;
   localparam int unsigned DEF_ARM_TICKS              = 2000;
   localparam int unsigned DEF_CADENCE_TIMEOUT_TICKS  = 20000;

   // Magnitude of a signed 12-bit angle; -2048 has no positive twin, so clamp it
   function automatic setting_t abs12(input logic signed [11:0] v);
      if (v == 12'sh800) return 12'h7FF;
      return v[11] ? setting_t'(-v) : setting_t'(v);
   endfunction

endpackage

// File: rtl/motor_mode_sequencer_if.sv
// Signal bundle between the sequencer and its source/sink blocks.
interface motor_mode_sequencer_if;
   import motor_seq_pkg::*;

   logic               tick;
   logic               MotorModeSelect;
   setting_t           AssistanceRequirement;
   setting_t           ThrottleTest;
   logic signed [11:0] ResolvedRoll;
   logic signed [11:0] ResolvedPitch;
   logic               cadence;
   setting_t           MotorCurrentSetting;
   logic [1:0]         SeqState;
   logic               TiltFault;

   modport master (
      output tick, MotorModeSelect, AssistanceRequirement, ThrottleTest,
             ResolvedRoll, ResolvedPitch, cadence,
      input  MotorCurrentSetting, SeqState, TiltFault
   );

   modport slave (
      input  tick, MotorModeSelect, AssistanceRequirement, ThrottleTest,
             ResolvedRoll, ResolvedPitch, cadence,
      output MotorCurrentSetting, SeqState, TiltFault
   );

endinterface

// File: rtl/ramp_limiter.sv
// Registered 12-bit value that walks toward a target by at most one step per enable,
// with an immediate force-to-zero.
module ramp_limiter
   import motor_seq_pkg::*;
(
   input  logic     c50m,
   input  logic     reset,
   input  logic     enable,
   input  logic     forceZero,
   input  setting_t target,
   input  setting_t step,
   output setting_t value
);

   setting_t gap;
   setting_t delta;

   always_comb begin
      gap   = (target > value) ? (target - value) : (value - target);
      delta = (gap > step) ? step : gap;
   end

   always_ff @(posedge c50m) begin
      if (reset || forceZero) begin
         value <= '0;
      end else if (enable) begin
         value <= (target > value) ? (value + delta) : (value - delta);
      end
   end

endmodule

// File: rtl/motor_mode_sequencer.sv
// Source select, arming interlock, tilt kill and rate-limited motor setting.
// Define MOTOR_SEQ_CADENCE_TIMEOUT_EN to enable cadence-timeout coasting.
//
// state | meaning
// IDLE  | setting 0; waits for the source to stay near zero for the arm period
// RUN   | setting ramps toward the selected source
// COAST | assist mode with no pedalling; setting ramps down to 0
// FAULT | roll/pitch past the limit; setting 0 until tilt clears
module motor_mode_sequencer
   import motor_seq_pkg::*;
#(
   parameter int unsigned TiltLimit           = DEF_TILT_LIMIT,
   parameter int unsigned RampStep            = DEF_RAMP_STEP,
   parameter int unsigned ZeroThresh          = DEF_ZERO_THRESH,
   parameter int unsigned ArmTicks            = DEF_ARM_TICKS,
   parameter int unsigned CadenceTimeoutTicks = DEF_CADENCE_TIMEOUT_TICKS
) (
   input logic                   c50m,
   input logic                   reset,
   motor_mode_sequencer_if.slave seqBus
);

   localparam logic [1:0]  ST_IDLE  = SEQ_IDLE;
   localparam logic [1:0]  ST_RUN   = SEQ_RUN;
   localparam logic [1:0]  ST_COAST = SEQ_COAST;
   localparam logic [1:0]  ST_FAULT = SEQ_FAULT;

   localparam setting_t    TILT_LIM = setting_t'(TiltLimit);
   localparam setting_t    STEP     = setting_t'(RampStep);
   localparam setting_t    ZERO_LIM = setting_t'(ZeroThresh);
   localparam logic [15:0] ARM_LIM  = 16'(ArmTicks);
   localparam logic [15:0] CAD_LIM  = 16'(CadenceTimeoutTicks);

   logic [1:0]  state;
   logic [1:0]  nextState;
   logic [15:0] armCnt;
   setting_t    source;
   setting_t    setting;
   logic        srcZero;
   logic        tilt;
   logic        cadEdge;
   logic        cadTimeout;
   logic        armDone;
   logic        stepEn;
   logic        forceZero;

   assign source  = seqBus.MotorModeSelect ? seqBus.AssistanceRequirement : seqBus.ThrottleTest;
   assign srcZero = (source <= ZERO_LIM);
   assign tilt    = (abs12(seqBus.ResolvedRoll) > TILT_LIM) ||
                    (abs12(seqBus.ResolvedPitch) > TILT_LIM);
   assign armDone = seqBus.tick && srcZero && ((armCnt + 16'd1) == ARM_LIM);

`ifdef MOTOR_SEQ_CADENCE_TIMEOUT_EN
   logic        cadSync1;
   logic        cadSync2;
   logic        cadSync3;
   logic [15:0] cadCnt;
   logic [15:0] cadCntInc;

   assign cadCntInc  = (cadCnt == CAD_LIM) ? CAD_LIM : (cadCnt + 16'd1);
   assign cadTimeout = seqBus.tick && !cadEdge && seqBus.MotorModeSelect && (cadCntInc == CAD_LIM);

   // Counter only runs while in RUN, so every entry to RUN starts a fresh timeout
   always_ff @(posedge c50m) begin
      if (reset) begin
         cadSync1 <= 1'b0;
         cadSync2 <= 1'b0;
         cadSync3 <= 1'b0;
         cadEdge  <= 1'b0;
         cadCnt   <= '0;
      end else begin
         cadSync1 <= seqBus.cadence;
         cadSync2 <= cadSync1;
         cadSync3 <= cadSync2;
         cadEdge  <= cadSync2 & ~cadSync3;
         if (state != ST_RUN || cadEdge) begin
            cadCnt <= '0;
         end else if (seqBus.tick) begin
            cadCnt <= cadCntInc;
         end
      end
   end
`else
   logic [16:0] unusedCadence;

   assign unusedCadence = {seqBus.cadence, CAD_LIM};
   assign cadEdge       = 1'b0;
   assign cadTimeout    = 1'b0;
`endif

   always_comb begin
      nextState = state;
      if (tilt) begin
         nextState = ST_FAULT;
      end else begin
         case (state)
            ST_IDLE:  if (armDone) nextState = ST_RUN;
            ST_RUN:   if (cadTimeout) nextState = ST_COAST;
            ST_COAST: if (cadEdge || !seqBus.MotorModeSelect) nextState = ST_RUN;
            ST_FAULT: nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge c50m) begin
      if (reset) begin
         state  <= ST_IDLE;
         armCnt <= '0;
      end else begin
         state <= nextState;
         if (state != ST_IDLE || (seqBus.tick && !srcZero)) begin
            armCnt <= '0;
         end else if (seqBus.tick && armCnt != ARM_LIM) begin
            armCnt <= armCnt + 16'd1;
         end
      end
   end

   // State changes take the tick; the setting only moves on ticks that stay put
   assign stepEn    = seqBus.tick && (nextState == state) && (state == ST_RUN || state == ST_COAST);
   assign forceZero = tilt || state == ST_IDLE || state == ST_FAULT;

   ramp_limiter uRamp (
      .c50m      (c50m),
      .reset     (reset),
      .enable    (stepEn),
      .forceZero (forceZero),
      .target    ((state == ST_COAST) ? setting_t'(0) : source),
      .step      (STEP),
      .value     (setting)
   );

   assign seqBus.MotorCurrentSetting = setting;
   assign seqBus.SeqState            = state;
   assign seqBus.TiltFault           = (state == ST_FAULT);

endmodule

// File: tb/tb_motor_mode_sequencer.sv
// Bench for motor_mode_sequencer: behavioural model compared every cycle plus
// hand-computed checkpoints. Honours MOTOR_SEQ_CADENCE_TIMEOUT_EN like the design.
module tb_motor_mode_sequencer;

`ifdef MOTOR_SEQ_CADENCE_TIMEOUT_EN
   localparam bit CAD_EN = 1'b1;
`else
   localparam bit CAD_EN = 1'b0;
`endif

   localparam int TILT = 512;
   localparam int STEP = 16;
   localparam int ZTH  = 32;
   localparam int ARM  = 2000;
   localparam int CADT = 20000;

   logic c50m;
   logic reset;
   motor_mode_sequencer_if seqBus ();

   motor_mode_sequencer dut (
      .c50m   (c50m),
      .reset  (reset),
      .seqBus (seqBus)
   );

   initial c50m = 1'b0;
   always #5 c50m = ~c50m;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;

   // Model: state as 0 idle / 1 run / 2 coast / 3 fault, plain integer setting
   int mState = 0;
   int mSet   = 0;
   int mArm   = 0;
   int mCad   = 0;
   bit [3:0] hist = '0;

   function automatic int absSat(input logic signed [11:0] v);
      int x;
      x = v;
      if (x < 0) x = -x;
      return (x > 2047) ? 2047 : x;
   endfunction

   function automatic int clampStep(input int d);
      if (d > STEP) return STEP;
      if (d < -STEP) return -STEP;
      return d;
   endfunction

   always @(posedge c50m) begin : model
      int ns, nset, narm, ncad, src;
      bit tiltNow, edgeNow;
      ns = mState; nset = mSet; narm = mArm; ncad = mCad;
      src = seqBus.MotorModeSelect ? int'(seqBus.AssistanceRequirement) : int'(seqBus.ThrottleTest);
      tiltNow = (absSat(seqBus.ResolvedRoll) > TILT) || (absSat(seqBus.ResolvedPitch) > TILT);
      // pin rise becomes an acted-on edge four samples later
      edgeNow = CAD_EN && hist[2] && !hist[3];
      if (reset) begin
         ns = 0; nset = 0; narm = 0; ncad = 0;
      end else if (tiltNow) begin
         ns = 3; nset = 0; narm = 0; ncad = 0;
      end else if (mState == 0) begin
         nset = 0;
         if (seqBus.tick) begin
            if (src <= ZTH) begin
               narm = mArm + 1;
               if (narm == ARM) begin ns = 1; narm = 0; ncad = 0; end
            end else begin
               narm = 0;
            end
         end
      end else if (mState == 1) begin
         if (edgeNow) ncad = 0;
         else if (seqBus.tick) begin
            ncad = (mCad + 1 > CADT) ? CADT : mCad + 1;
            if (CAD_EN && ncad == CADT && seqBus.MotorModeSelect) ns = 2;
         end
         if (seqBus.tick && ns == 1) nset = mSet + clampStep(src - mSet);
      end else if (mState == 2) begin
         if (edgeNow || !seqBus.MotorModeSelect) begin ns = 1; ncad = 0; end
         else if (seqBus.tick) nset = (mSet > STEP) ? mSet - STEP : 0;
      end else begin
         ns = 0; nset = 0;
      end
      mState <= ns; mSet <= nset; mArm <= narm; mCad <= ncad;
      hist   <= reset ? 4'b0 : {hist[2:0], seqBus.cadence};
   end

   always @(negedge c50m) begin
      if (checkEn) begin
         checks += 3;
         if (int'(seqBus.SeqState) != mState) begin
            errors++;
            $display("FAIL cyc SeqState got %0d want %0d at %0t", seqBus.SeqState, mState, $time);
         end
         if (int'(seqBus.MotorCurrentSetting) != mSet) begin
            errors++;
            $display("FAIL cyc setting got %0d want %0d at %0t", seqBus.MotorCurrentSetting, mSet, $time);
         end
         if (seqBus.TiltFault != (mState == 3)) begin
            errors++;
            $display("FAIL cyc TiltFault got %0d want %0d at %0t", seqBus.TiltFault, (mState == 3), $time);
         end
      end
   end

   task automatic lit(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, exp);
      end
   endtask

   task automatic cyc(input bit t);
      seqBus.tick = t;
      @(posedge c50m);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1);
      seqBus.tick = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      cyc(1'b0);
      reset = 1'b0;
   endtask

   int rampTab[7] = '{16, 32, 48, 64, 80, 96, 100};

   initial begin
      reset = 1'b1;
      seqBus.tick = 1'b0;
      seqBus.MotorModeSelect = 1'b0;
      seqBus.AssistanceRequirement = '0;
      seqBus.ThrottleTest = '0;
      seqBus.ResolvedRoll = '0;
      seqBus.ResolvedPitch = '0;
      seqBus.cadence = 1'b0;
      cyc(1'b0);
      cyc(1'b0);
      checkEn = 1'b1;
      reset = 1'b0;
      lit("resetState", seqBus.SeqState, 0);
      lit("resetSetting", seqBus.MotorCurrentSetting, 0);
      lit("resetTilt", seqBus.TiltFault, 0);

      // throttle arm then ramp to 100
      ticks(1999);
      lit("armNotYet", seqBus.SeqState, 0);
      ticks(1);
      lit("armRun", seqBus.SeqState, 1);
      lit("armRunModel", mState, 1);
      seqBus.ThrottleTest = 12'd100;
      cyc(1'b0);
      lit("noTickHold", seqBus.MotorCurrentSetting, 0);
      for (int i = 0; i < 7; i++) begin
         ticks(1);
         lit("ramp", seqBus.MotorCurrentSetting, rampTab[i]);
         lit("rampModel", mSet, rampTab[i]);
      end
      ticks(3);
      lit("rampSettled", seqBus.MotorCurrentSetting, 100);

      // non-zero source blocks arming
      doReset();
      lit("reset2", seqBus.MotorCurrentSetting, 0);
      seqBus.ThrottleTest = 12'd500;
      ticks(5000);
      lit("blockedIdle", seqBus.SeqState, 0);
      lit("blockedSet", seqBus.MotorCurrentSetting, 0);
      seqBus.ThrottleTest = 12'd0;
      ticks(1999);
      lit("rearmNotYet", seqBus.SeqState, 0);
      ticks(1);
      lit("rearmRun", seqBus.SeqState, 1);

      // tilt kill without tick, re-arm required after clear
      seqBus.ThrottleTest = 12'd800;
      ticks(50);
      lit("at800", seqBus.MotorCurrentSetting, 800);
      seqBus.ResolvedRoll = -12'sd600;
      cyc(1'b0);
      lit("rollFaultState", seqBus.SeqState, 3);
      lit("rollFaultSet", seqBus.MotorCurrentSetting, 0);
      lit("rollFaultFlag", seqBus.TiltFault, 1);
      ticks(3);
      lit("faultHeld", seqBus.SeqState, 3);
      seqBus.ResolvedRoll = 12'sd0;
      cyc(1'b0);
      lit("faultClear", seqBus.SeqState, 0);
      ticks(10);
      lit("needRearm", seqBus.SeqState, 0);
      lit("needRearmSet", seqBus.MotorCurrentSetting, 0);

      // assist mode, cadence timeout
      doReset();
      seqBus.ThrottleTest = 12'd0;
      seqBus.MotorModeSelect = 1'b1;
      ticks(2000);
      lit("assistRun", seqBus.SeqState, 1);
      seqBus.AssistanceRequirement = 12'd320;
      ticks(20);
      lit("at320", seqBus.MotorCurrentSetting, 320);
      ticks(19979);
      lit("preTimeout", seqBus.SeqState, 1);
      ticks(1);
`ifdef MOTOR_SEQ_CADENCE_TIMEOUT_EN
      lit("timeoutCoast", seqBus.SeqState, 2);
      ticks(1);
      lit("coast304", seqBus.MotorCurrentSetting, 304);
      ticks(1);
      lit("coast288", seqBus.MotorCurrentSetting, 288);
      ticks(18);
      lit("coastZero", seqBus.MotorCurrentSetting, 0);
      lit("coastZeroModel", mSet, 0);
`else
      lit("noCoast", seqBus.SeqState, 1);
      ticks(20);
      lit("holds320", seqBus.MotorCurrentSetting, 320);
`endif
      seqBus.cadence = 1'b1;
      cyc(1'b0);
      cyc(1'b0);
      seqBus.cadence = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1'b0);
      lit("cadenceRun", seqBus.SeqState, 1);
      ticks(5);
`ifdef MOTOR_SEQ_CADENCE_TIMEOUT_EN
      lit("rampBack", seqBus.MotorCurrentSetting, 80);
`else
      lit("rampBack", seqBus.MotorCurrentSetting, 320);
`endif

      // pitch boundaries
      seqBus.ResolvedPitch = 12'sh800;
      cyc(1'b0);
      lit("pitchMin", seqBus.SeqState, 3);
      seqBus.ResolvedPitch = 12'sd512;
      cyc(1'b0);
      cyc(1'b0);
      lit("pitch512", seqBus.TiltFault, 0);
      lit("pitch512State", seqBus.SeqState, 0);
      seqBus.ResolvedPitch = 12'sd513;
      cyc(1'b0);
      lit("pitch513", seqBus.TiltFault, 1);
      seqBus.ResolvedPitch = 12'sd0;
      seqBus.ResolvedRoll = 12'sd2047;
      cyc(1'b0);
      lit("roll2047", seqBus.SeqState, 3);
      seqBus.ResolvedRoll = 12'sd0;
      cyc(1'b0);

      // reset mid-ramp
      doReset();
      seqBus.MotorModeSelect = 1'b0;
      seqBus.ThrottleTest = 12'd0;
      ticks(2000);
      seqBus.ThrottleTest = 12'd1000;
      ticks(25);
      lit("at400", seqBus.MotorCurrentSetting, 400);
      reset = 1'b1;
      cyc(1'b1);
      reset = 1'b0;
      seqBus.tick = 1'b0;
      lit("midRampResetSet", seqBus.MotorCurrentSetting, 0);
      lit("midRampResetState", seqBus.SeqState, 0);
      cyc(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
